// File: rtl/r_pipe_hazard_ctrl_if.sv
// Bundle between the hazard controller and its pipeline/instruction-memory environment.
// The controller sits on the slave modport. The environment (datapath, imem, bench) sits on master.
interface r_pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    // start is a level that is sampled only in IDLE. There is no ready:
    // busy and done report run progress, and stall/bubble qualify ID->EX each cycle.
    logic             start;
    logic [31:0]      if_instr;
    logic [31:0]      pc;
    logic [31:0]      id_instr;
    logic             id_valid;
    logic             bubble;
    logic             stall;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] retired_cnt;
    logic [1:0]       state;

    modport master (
        output start, if_instr,
        input  pc, id_instr, id_valid, bubble, stall, busy, done,
               stall_cnt, retired_cnt, state
    );

    modport slave (
        input  start, if_instr,
        output pc, id_instr, id_valid, bubble, stall, busy, done,
               stall_cnt, retired_cnt, state
    );
endinterface

// File: rtl/r_pipe_hazard_ctrl.sv
// PC/IF-ID sequencer with RAW-hazard stall control for a five-stage, no-forwarding R-type pipe.
// Optional macro HAZARD_WB_BYPASS_EN: the RF is write-through, so the WB entry is excluded from the hazard compare.
module r_pipe_hazard_ctrl #(
    parameter logic [31:0] PC_RESET  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
    parameter int          CNT_W     = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    r_pipe_hazard_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    typedef struct packed {
        logic       valid;
        logic       wr;
        logic [4:0] rd;
    } sb_t;

    state_t           state;
    sb_t              sb_ex, sb_mem, sb_wb, ex_next;
    logic [31:0]      pc_q, id_instr_q;
    logic             id_valid_q, busy_q, done_q;
    logic [CNT_W-1:0] stall_q, retired_q;
    logic [4:0]       rs, rt;
    logic             hazard, stall, advance, id_wr, drained;

    function automatic logic hits(input sb_t e, input logic [4:0] a, input logic [4:0] b);
        return e.valid && e.wr && ((a != 5'd0 && a == e.rd) || (b != 5'd0 && b == e.rd));
    endfunction

    always_comb begin
        rs = id_instr_q[25:21];
        rt = id_instr_q[20:16];
`ifdef HAZARD_WB_BYPASS_EN
        hazard = id_valid_q && (hits(sb_ex, rs, rt) || hits(sb_mem, rs, rt));
`else
        hazard = id_valid_q && (hits(sb_ex, rs, rt) || hits(sb_mem, rs, rt) || hits(sb_wb, rs, rt));
`endif
        stall   = hazard && (state == RUN || state == DRAIN);
        advance = id_valid_q && !stall;
        id_wr   = (id_instr_q[31:26] == 6'b000000) && (id_instr_q[15:11] != 5'd0);
        ex_next = '0;
        if (advance) begin
            ex_next.valid = 1'b1;
            ex_next.wr    = id_wr;
            ex_next.rd    = id_instr_q[15:11];
        end
        drained = !id_valid_q && !sb_ex.valid && !sb_mem.valid && !sb_wb.valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc_q       <= PC_RESET;
            id_instr_q <= '0;
            id_valid_q <= 1'b0;
            sb_ex      <= '0;
            sb_mem     <= '0;
            sb_wb      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            stall_q    <= '0;
            retired_q  <= '0;
        end else begin
            sb_ex  <= ex_next;
            sb_mem <= sb_ex;
            sb_wb  <= sb_mem;
            done_q <= 1'b0;
            if (stall && stall_q != '1)
                stall_q <= stall_q + CNT_W'(1);
            if (sb_wb.valid && retired_q != '1)
                retired_q <= retired_q + CNT_W'(1);

            case (state)
                IDLE: begin
                    pc_q       <= PC_RESET;
                    id_instr_q <= '0;
                    id_valid_q <= 1'b0;
                    if (bus.start) begin
                        state  <= RUN;
                        busy_q <= 1'b1;
                    end
                end
                RUN: begin
                    // Halt detection only happens on cycles where fetch actually advances.
                    if (!stall) begin
                        if (bus.if_instr != HALT_WORD) begin
                            pc_q       <= pc_q + 32'd4;
                            id_instr_q <= bus.if_instr;
                            id_valid_q <= 1'b1;
                        end else begin
                            id_instr_q <= '0;
                            id_valid_q <= 1'b0;
                            state      <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!stall) begin
                        id_instr_q <= '0;
                        id_valid_q <= 1'b0;
                    end
                    if (drained) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    pc_q  <= PC_RESET;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.pc          = pc_q;
    assign bus.id_instr    = id_instr_q;
    assign bus.id_valid    = id_valid_q;
    assign bus.bubble      = !advance;
    assign bus.stall       = stall;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.stall_cnt   = stall_q;
    assign bus.retired_cnt = retired_q;
    assign bus.state       = state;
endmodule

// File: tb/tb_r_pipe_hazard_ctrl.sv
// Directed bench for r_pipe_hazard_ctrl: small programs from a bench-side instruction memory,
// with stall/retire/pc expectations worked out by hand from the pipeline timing.
module tb_r_pipe_hazard_ctrl;
    localparam logic [31:0] PC_RESET = 32'h0000_0000;
    localparam logic [31:0] HALT     = 32'hFFFF_FFFF;
`ifdef HAZARD_WB_BYPASS_EN
    localparam int DEP1 = 2;
    localparam int DEP2 = 1;
`else
    localparam int DEP1 = 3;
    localparam int DEP2 = 2;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    r_pipe_hazard_ctrl_if #(.CNT_W(16)) bus();

    r_pipe_hazard_ctrl #(
        .PC_RESET(PC_RESET),
        .HALT_WORD(HALT),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    logic [31:0] imem [64];
    assign bus.if_instr = imem[bus.pc[7:2]];

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_stall, n_stall_bub, n_stall_pc, n_done;
    logic [31:0] done_pc;
    int          exp_stall_tot = 0;
    int          exp_ret_tot   = 0;

    function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [5:0] funct);
        return {6'b000000, rs, rt, rd, 5'b00000, funct};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) imem[i] = HALT;
    endtask

    task automatic start_run();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_after_start", {31'd0, bus.busy}, 32'd1);
    endtask

    task automatic run_to_done(input int budget, input logic [31:0] hold_pc, input bit poke);
        bit seen;
        seen = 1'b0;
        n_stall = 0; n_stall_bub = 0; n_stall_pc = 0; n_done = 0; done_pc = '0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (poke) bus.start = (c == 3);
            if (bus.stall) begin
                n_stall++;
                if (bus.bubble) n_stall_bub++;
                if (bus.pc == hold_pc) n_stall_pc++;
            end
            if (bus.done) begin
                n_done++;
                done_pc = bus.pc;
                seen = 1'b1;
                break;
            end
        end
        bus.start = 1'b0;
        chk("run_done_seen", {31'd0, seen}, 32'd1);
        @(negedge clk);
        if (bus.done) n_done++;
        chk("done_pulse_count", n_done, 32'd1);
        chk("idle_busy", {31'd0, bus.busy}, 32'd0);
        chk("idle_pc", bus.pc, PC_RESET);
    endtask

    task automatic chk_counters(input string tag);
        chk({tag, "_stall_cnt"}, {16'd0, bus.stall_cnt}, exp_stall_tot);
        chk({tag, "_retired_cnt"}, {16'd0, bus.retired_cnt}, exp_ret_tot);
    endtask

    initial begin
        bit got;
        bus.start = 1'b0;
        clear_mem();

        // Reset values
        #2 rst_n = 1'b0;
        #1;
        chk("rst_pc", bus.pc, PC_RESET);
        chk("rst_id_valid", {31'd0, bus.id_valid}, 32'd0);
        chk("rst_id_instr", bus.id_instr, 32'd0);
        chk("rst_bubble", {31'd0, bus.bubble}, 32'd1);
        chk("rst_stall", {31'd0, bus.stall}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk_counters("rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // A: five independent writers then halt
        clear_mem();
        for (int i = 0; i < 5; i++) imem[i] = rtype(5'(i + 1), 5'd10, 5'd11, 6'h20);
        start_run();
        @(negedge clk);
        chk("a_first_id_valid", {31'd0, bus.id_valid}, 32'd1);
        chk("a_first_id_instr", bus.id_instr, rtype(5'd1, 5'd10, 5'd11, 6'h20));
        chk("a_first_pc", bus.pc, PC_RESET + 32'd4);
        run_to_done(60, 32'hDEAD_BEEF, 1'b0);
        chk("a_stalls", n_stall, 32'd0);
        chk("a_done_pc", done_pc, PC_RESET + 32'd20);
        exp_ret_tot += 5;
        chk_counters("a");

        // B: back-to-back RAW pair
        clear_mem();
        imem[0] = rtype(5'd3, 5'd1, 5'd2, 6'h20);
        imem[1] = rtype(5'd4, 5'd3, 5'd1, 6'h22);
        start_run();
        run_to_done(60, PC_RESET + 32'd8, 1'b0);
        chk("b_stalls", n_stall, DEP1);
        chk("b_stall_bubbles", n_stall_bub, DEP1);
        chk("b_stall_pc_held", n_stall_pc, DEP1);
        exp_stall_tot += DEP1;
        exp_ret_tot   += 2;
        chk_counters("b");

        // C: register $0 never hazards
        clear_mem();
        imem[0] = rtype(5'd0, 5'd1, 5'd2, 6'h20);
        imem[1] = rtype(5'd5, 5'd0, 5'd0, 6'h25);
        start_run();
        run_to_done(60, 32'hDEAD_BEEF, 1'b0);
        chk("c_stalls", n_stall, 32'd0);
        exp_ret_tot += 2;
        chk_counters("c");

        // D: dependency two apart
        clear_mem();
        imem[0] = rtype(5'd3, 5'd1, 5'd2, 6'h20);
        imem[1] = rtype(5'd6, 5'd7, 5'd8, 6'h20);
        imem[2] = rtype(5'd4, 5'd3, 5'd1, 6'h22);
        start_run();
        run_to_done(60, PC_RESET + 32'd12, 1'b0);
        chk("d_stalls", n_stall, DEP2);
        chk("d_stall_pc_held", n_stall_pc, DEP2);
        exp_stall_tot += DEP2;
        exp_ret_tot   += 3;
        chk_counters("d");

        // E: start pulsed mid-run is ignored
        clear_mem();
        for (int i = 0; i < 5; i++) imem[i] = rtype(5'(i + 1), 5'd10, 5'd11, 6'h20);
        start_run();
        run_to_done(60, 32'hDEAD_BEEF, 1'b1);
        chk("e_stalls", n_stall, 32'd0);
        chk("e_done_pc", done_pc, PC_RESET + 32'd20);
        exp_ret_tot += 5;
        chk_counters("e");

        // F: reset during a stall, then a fresh run
        clear_mem();
        imem[0] = rtype(5'd3, 5'd1, 5'd2, 6'h20);
        imem[1] = rtype(5'd4, 5'd3, 5'd1, 6'h22);
        start_run();
        got = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.stall) begin
                got = 1'b1;
                break;
            end
        end
        chk("f_stall_seen", {31'd0, got}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("f_rst_pc", bus.pc, PC_RESET);
        chk("f_rst_id_valid", {31'd0, bus.id_valid}, 32'd0);
        chk("f_rst_busy", {31'd0, bus.busy}, 32'd0);
        exp_stall_tot = 0;
        exp_ret_tot   = 0;
        chk_counters("f_rst");
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.done) n_done++;
        end
        chk("f_no_done", n_done, 32'd0);
        start_run();
        run_to_done(60, PC_RESET + 32'd8, 1'b0);
        chk("f_stalls", n_stall, DEP1);
        exp_stall_tot += DEP1;
        exp_ret_tot   += 2;
        chk_counters("f");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/r_pipe_hazard_ctrl.md
# r_pipe_hazard_ctrl

Sequencer and hazard controller for the five-stage R-type pipeline (IF, ID, EX, MEM, WB). It owns the PC and the IF/ID register, and tracks the destination registers of in-flight instructions. The datapath has no forwarding, so on a read-after-write hazard it stalls fetch and decode and injects bubbles into EX. A start/halt FSM runs a program from a reset PC until a sentinel halt word is fetched and the pipeline has drained.

## Interface
Parameters:
- PC_RESET, 32'h0000_0000, PC value after reset and on return to IDLE
- HALT_WORD, 32'hFFFF_FFFF, fetched instruction that ends the program
- CNT_W, 16, width of the performance counters

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  sampled in IDLE only; launches a run
- if_instr  in  32  instruction-memory output for the current `pc`
- pc  out  32  fetch address to instruction memory
- id_instr  out  32  IF/ID register contents, feeding RF addresses and control decode
- id_valid  out  1  `id_instr` holds a real instruction
- bubble  out  1  high: the datapath loads all-zero control into ID/EX this edge
- stall  out  1  high: the hazard holds the PC and IF/ID this cycle
- busy  out  1  state is RUN or DRAIN
- done  out  1  one-cycle pulse at the end of a run
- stall_cnt  out  CNT_W  count of stall cycles, saturating
- retired_cnt  out  CNT_W  count of instructions leaving WB, saturating

## Operation
- Writer decode: an instruction writes the RF iff opcode [31:26] == 6'b000000 and rd [15:11] != 0.
- Scoreboard: three entries {valid, wr, rd} for EX, MEM and WB. Each entry shifts one stage per edge (EX→MEM→WB→discarded).
- Loading EX:
  - EX loads from ID when `id_valid` && !stall.
  - Otherwise EX loads an invalid entry, and `bubble` = 1.
- Hazard (combinational):
  - Condition: `id_valid` and either rs [25:21] or rt [20:16] is non-zero and equals the rd of a valid, wr entry in EX, MEM or WB.
  - Register $0 never hazards.
  - `stall` = hazard && (state == RUN || state == DRAIN).
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE:
    - `pc` = PC_RESET; IF/ID is invalid.
    - `start` = 1 moves to RUN.
  - RUN, stall = 0, `if_instr` != HALT_WORD: `pc` <= `pc` + 4 (mod 2^32); IF/ID <= {`if_instr`, valid}.
  - RUN, stall = 0, `if_instr` == HALT_WORD: `pc` holds; IF/ID <= invalid; move to DRAIN.
  - RUN or DRAIN, stall = 1: `pc` and IF/ID hold.
  - DRAIN:
    - No fetch.
    - The ID instruction advances when it is hazard-free.
    - Moves to DONE when IF/ID and all three scoreboard entries are invalid.
  - DONE: `done` = 1 for one cycle, then IDLE.
  - `start` is ignored outside IDLE.
- Counters:
  - `stall_cnt` increments on each cycle with `stall` = 1.
  - `retired_cnt` increments on each edge where the WB entry is valid.
  - Both saturate at all-ones.
  - Both clear only on reset; they hold across runs.
- Precedence: HALT_WORD is checked only on non-stalled RUN cycles.

## Timing
- Reset values (asynchronous, immediate):
  - `pc` = PC_RESET.
  - `id_instr` = 0; `id_valid` = 0.
  - Scoreboard entries invalid.
  - `bubble` = 1; `stall` = 0; `busy` = 0; `done` = 0.
  - Counters = 0.
  - State = IDLE.
- Reset mid-run aborts with no drain, and `done` is not pulsed.
- `start` is sampled at edge E0; `busy` goes high after E0. The first instruction (at PC_RESET) is captured into IF/ID at E1.
- Instruction in ID at edge-cycle n: EX at n+1, MEM at n+2, WB at n+3. It is counted retired at the edge that ends its WB cycle.
- Dependent back-to-back pair: 3 stall cycles (2 with bypass, see Configuration).
- `stall`, `bubble` and `id_*` are valid combinationally within each cycle.
- Counter and pc updates are visible one edge later.

## Configuration
- HAZARD_WB_BYPASS_EN:
  - Defined: the RF is write-through (a write in WB is visible to the same-cycle ID read), so the WB entry is excluded from hazard compare.
  - Undefined: EX, MEM and WB are all compared.

## Test plan
- Five independent R-type instructions, then HALT_WORD → `stall_cnt` = 0, `retired_cnt` = 5, `done` pulses once, final `pc` = PC_RESET+20 before IDLE resets it.
- add $3,$1,$2 ; sub $4,$3,$1 → 3 stall cycles with `pc` held at PC_RESET+8 and 3 bubbles. With HAZARD_WB_BYPASS_EN: 2 stall cycles.
- add $0,$1,$2 ; or $5,$0,$0 → no stall; `stall_cnt` stays 0.
- Dependency 2 apart (add $3.. ; add $6,$7,$8 ; sub $4,$3,$1) → 2 stall cycles (1 with bypass).
- `start` pulsed while `busy` = 1 → no effect: pc sequence and counters unchanged.
- rst_n asserted mid-run during a stall → immediate `pc` = PC_RESET, `id_valid` = 0, counters = 0, no `done` pulse. A new `start` runs correctly.
